// File: rtl/alu_pkg.sv
// Shared constants for the ALU arbiter: ALUConf operation codes and FSM state encoding.
package alu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_OR   = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_SUB  = 5'b00110;
    localparam logic [4:0] ALU_SLT  = 5'b00111;
    localparam logic [4:0] ALU_NOR  = 5'b01100;
    localparam logic [4:0] ALU_XOR  = 5'b01101;
    localparam logic [4:0] ALU_SRL  = 5'b10000;
    localparam logic [4:0] ALU_SRA  = 5'b11000;
    localparam logic [4:0] ALU_SLL  = 5'b11001;
    localparam logic [4:0] ALU_ANDN = 5'b11010;
    localparam logic [4:0] ALU_ADDU = 5'b11011;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: In1/In2 operands, ALUConf code, signed-compare select; shifts move In2 by In1[4:0].
module alu_arbiter_alu
    import alu_pkg::*;
(
    input  logic [4:0]        conf,
    input  logic              sign,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              overflow
);

    logic signed [DATA_W-1:0] in1_s;
    logic signed [DATA_W-1:0] in2_s;
    logic        [DATA_W-1:0] sum;
    logic                     less;

    assign in1_s = in1;
    assign in2_s = in2;
    assign sum   = in1 + in2;
    assign less  = sign ? (in1_s < in2_s) : (in1 < in2);

    always_comb begin
        result = '0;
        unique case (conf)
            ALU_ADD,
            ALU_ADDU: result = sum;
            ALU_OR:   result = in1 | in2;
            ALU_AND:  result = in1 & in2;
            ALU_SUB:  result = in1 - in2;
            ALU_SLT:  result = {{(DATA_W-1){1'b0}}, less};
            ALU_NOR:  result = ~(in1 | in2);
            ALU_XOR:  result = in1 ^ in2;
            ALU_SRL:  result = in2 >> in1[4:0];
            ALU_SRA:  result = in2_s >>> in1[4:0];
            ALU_SLL:  result = in2 << in1[4:0];
            ALU_ANDN: result = in1 & ~in2;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

    // Only the checked add reports overflow: like-signed operands whose sum flips sign.
    assign overflow = (conf == ALU_ADD) && (in1[DATA_W-1] == in2[DATA_W-1])
                      && (sum[DATA_W-1] != in1[DATA_W-1]);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one ALU: IDLE accepts and latches, EXEC computes, RESP reports done.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [4:0]        conf0,
    input  logic [4:0]        conf1,
    input  logic              sign0,
    input  logic              sign1,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] b1,
    output logic              grant0,
    output logic              grant1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              overflow,
    output logic              busy
);

    state_t            state;
    state_t            state_nxt;
    logic              any_req;
    logic              pick;
    logic              winner;
    logic              last_served;
    logic [4:0]        conf_l;
    logic              sign_l;
    logic [DATA_W-1:0] a_l;
    logic [DATA_W-1:0] b_l;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_overflow;

    assign any_req = req0 | req1;

    // A lone requester always wins; ties go to fixed priority or away from the last served.
    always_comb begin
        pick = 1'b0;
        if (req1 && !req0)
            pick = 1'b1;
        else if (req0 && req1 && !FIXED_PRIO)
            pick = ~last_served;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (any_req) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        grant0 = (state == ST_EXEC) && !winner;
        grant1 = (state == ST_EXEC) &&  winner;
        done0  = (state == ST_RESP) && !winner;
        done1  = (state == ST_RESP) &&  winner;
        busy   = (state != ST_IDLE);
    end

    // Operand latch at accept, result capture at EXEC->RESP, fairness update at RESP->IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            winner      <= 1'b0;
            last_served <= 1'b1;
            conf_l      <= '0;
            sign_l      <= 1'b0;
            a_l         <= '0;
            b_l         <= '0;
            result      <= '0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        winner <= pick;
                        conf_l <= pick ? conf1 : conf0;
                        sign_l <= pick ? sign1 : sign0;
                        a_l    <= pick ? a1 : a0;
                        b_l    <= pick ? b1 : b0;
                    end
                end
                ST_EXEC: begin
                    result   <= alu_result;
                    zero     <= alu_zero;
                    overflow <= alu_overflow;
                end
                ST_RESP: last_served <= winner;
                default: ;
            endcase
        end
    end

    alu_arbiter_alu u_alu (
        .conf     (conf_l),
        .sign     (sign_l),
        .in1      (a_l),
        .in2      (b_l),
        .result   (alu_result),
        .zero     (alu_zero),
        .overflow (alu_overflow)
    );

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed ops push expectations, a negedge monitor pops on done.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [4:0]  conf0 = '0, conf1 = '0;
    logic        sign0 = 1'b0, sign1 = 1'b0;
    logic [31:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic        grant0, grant1, done0, done1, zero, overflow, busy;
    logic [31:0] result;

    logic        fp_req0 = 1'b0, fp_req1 = 1'b0;
    logic        fp_grant0, fp_grant1, fp_done0, fp_done1, fp_zero, fp_overflow, fp_busy;
    logic [31:0] fp_result;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        bit          id;
        logic [31:0] res;
        logic        z;
        logic        o;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_arbiter #(.FIXED_PRIO(1'b0)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .conf0(conf0), .conf1(conf1), .sign0(sign0), .sign1(sign1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1),
        .result(result), .zero(zero), .overflow(overflow), .busy(busy)
    );

    alu_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .reset(reset), .req0(fp_req0), .req1(fp_req1),
        .conf0(conf0), .conf1(conf1), .sign0(sign0), .sign1(sign1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .grant0(fp_grant0), .grant1(fp_grant1), .done0(fp_done0), .done1(fp_done1),
        .result(fp_result), .zero(fp_zero), .overflow(fp_overflow), .busy(fp_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (grant0 && grant1) check("double_grant", 32'd1, 32'd0);
        if (done0 || done1) begin
            check("done_onehot", {31'd0, done0 && done1}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", {30'd0, done1, done0}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("done_id", {31'd0, done1}, {31'd0, e.id});
                check("result", result, e.res);
                check("zero", {31'd0, zero}, {31'd0, e.z});
                check("overflow", {31'd0, overflow}, {31'd0, e.o});
            end
        end
    end

    task automatic push(input bit id, input logic [31:0] r, input logic z, input logic o);
        exp_t e;
        e.id = id; e.res = r; e.z = z; e.o = o;
        sb.push_back(e);
    endtask

    task automatic set_op(input bit id, input logic [4:0] c, input logic s,
                          input logic [31:0] a, input logic [31:0] b);
        if (id) begin conf1 = c; sign1 = s; a1 = a; b1 = b; end
        else    begin conf0 = c; sign0 = s; a0 = a; b0 = b; end
    endtask

    // Waits for the requester's done (bounded), then drops its req just after the RESP->IDLE edge.
    task automatic wait_done(input bit id);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = id ? done1 : done0;
        end
        if (!seen) check(id ? "timeout_done1" : "timeout_done0", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (id) req1 = 1'b0; else req0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_single(input bit id, input logic [4:0] c, input logic s,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] r, input logic z, input logic o);
        push(id, r, z, o);
        set_op(id, c, s, a, b);
        if (id) req1 = 1'b1; else req0 = 1'b1;
        wait_done(id);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        check("rst_grant", {30'd0, grant1, grant0}, 32'd0);
        check("rst_done", {30'd0, done1, done0}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {30'd0, zero, overflow}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int n;
        int fp_g0, fp_g1, fp_dbl;
        do_reset();

        // Single ADD with explicit grant/done timing.
        push(1'b0, 32'd12, 1'b0, 1'b0);
        set_op(1'b0, ALU_ADD, 1'b0, 32'd5, 32'd7);
        req0 = 1'b1;
        @(negedge clk);
        check("add_grant0", {30'd0, grant1, grant0}, 32'd1);
        check("add_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("add_done0", {30'd0, done1, done0}, 32'd1);
        @(posedge clk); #1; req0 = 1'b0;
        @(negedge clk);

        // Simultaneous requests after reset: 0 first, then 1, then 0 again.
        do_reset();
        push(1'b0, 32'd0, 1'b1, 1'b0);
        push(1'b1, 32'h0000_00FF, 1'b0, 1'b0);
        set_op(1'b0, ALU_SUB, 1'b0, 32'd3, 32'd3);
        set_op(1'b1, ALU_OR, 1'b0, 32'h0000_00F0, 32'h0000_000F);
        req0 = 1'b1; req1 = 1'b1;
        wait_done(1'b0);
        wait_done(1'b1);
        push(1'b0, 32'd0, 1'b1, 1'b0);
        push(1'b1, 32'h0000_00FF, 1'b0, 1'b0);
        req0 = 1'b1; req1 = 1'b1;
        wait_done(1'b0);
        wait_done(1'b1);

        do_single(1'b1, ALU_ADD,  1'b0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1);
        do_single(1'b1, ALU_ADDU, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0);
        do_single(1'b0, ALU_SLT,  1'b1, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
        do_single(1'b0, ALU_SLT,  1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
        do_single(1'b1, ALU_ANDN, 1'b0, 32'h0000_FF0F, 32'h0000_0F0F, 32'h0000_F000, 1'b0, 1'b0);
        do_single(1'b0, ALU_SLL,  1'b0, 32'd8, 32'h0000_00AB, 32'h0000_AB00, 1'b0, 1'b0);
        do_single(1'b1, 5'b11111, 1'b0, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0);
        do_single(1'b0, ALU_SRA,  1'b0, 32'd4, 32'h8000_0000, 32'hF800_0000, 1'b0, 1'b0);
        @(negedge clk);
        check("result_hold", result, 32'hF800_0000);

        // Reset during EXEC aborts without a later done.
        set_op(1'b0, ALU_ADD, 1'b0, 32'd1, 32'd1);
        req0 = 1'b1;
        @(negedge clk);
        check("abort_grant", {30'd0, grant1, grant0}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort_grant_clr", {30'd0, grant1, grant0}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_result", result, 32'd0);
        req0 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            n += int'(done0) + int'(done1);
        end
        check("abort_no_done", n, 32'd0);
        do_single(1'b0, ALU_ADD, 1'b0, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0);

        // Fixed priority instance: requester 1 starves.
        fp_g0 = 0; fp_g1 = 0; fp_dbl = 0;
        fp_req0 = 1'b1; fp_req1 = 1'b1;
        repeat (30) begin
            @(negedge clk);
            fp_g0 += int'(fp_grant0);
            fp_g1 += int'(fp_grant1);
            fp_dbl += int'(fp_grant0 && fp_grant1);
        end
        fp_req0 = 1'b0; fp_req1 = 1'b0;
        check("fp_grant0_count", fp_g0, 32'd10);
        check("fp_grant1_count", fp_g1, 32'd0);
        check("fp_double_grant", fp_dbl, 32'd0);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
